shift_sequencer: RTL and testbench

//  Multi-cycle controller that runs SLL, SRL, SRA and ROTL on the shared 32-bit left-only barrel shifter.

---
 rtl/shift_pkg.sv | 28 ++
 rtl/shift_sequencer.sv | 127 ++++++++++++
 tb/tb_shift_sequencer.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift sequencer: op codes, FSM state encoding
// and the 32-bit bit-reversal helper used to turn right shifts into left shifts.
package shift_pkg;

   localparam int WIDTH   = 32;
   localparam int SHAMT_W = 5;

   localparam logic [1:0] OP_SLL  = 2'b00;
   localparam logic [1:0] OP_SRL  = 2'b01;
   localparam logic [1:0] OP_SRA  = 2'b10;
   localparam logic [1:0] OP_ROTL = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_P1   = 2'd1,
      ST_P2   = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   function automatic logic [31:0] rev32(input logic [31:0] x);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = x[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Sequences SLL/SRL/SRA/ROTL over an external left-only barrel shifter, using
// one pass for plain shifts and a second pass for SRA sign fill and ROTL wrap.
module shift_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  in_op,
   input  logic [31:0] in_data,
   input  logic [4:0]  in_amt,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic [31:0] sh_a,
   output logic [4:0]  sh_b,
   input  logic [31:0] sh_out
);
   import shift_pkg::*;

   state_e      state_q;
   logic [1:0]  op_q;
   logic [31:0] data_q;
   logic [4:0]  amt_q;
   logic [31:0] r1_q;
   logic [31:0] result_q;
   logic [31:0] sh_a_q;
   logic [4:0]  sh_b_q;
   logic        in_ready_q;
   logic        out_valid_q;

   logic [31:0] rev_out_d;
   logic [31:0] r1_d;
   logic        two_pass_d;
   logic [31:0] p2_res_d;
   logic [31:0] p1_a_d;
   logic [31:0] p2_a_d;
   logic [4:0]  p2_b_d;
   logic        in_rev_d;
   logic        q_rev_d;

   // Operand selection and result recombination around the shared shifter
   always_comb begin
      in_rev_d   = (in_op == OP_SRL) || (in_op == OP_SRA);
      q_rev_d    = (op_q == OP_SRL) || (op_q == OP_SRA);
      rev_out_d  = rev32(sh_out);
      r1_d       = q_rev_d ? rev_out_d : sh_out;
      two_pass_d = (amt_q != 5'd0) &&
                   (((op_q == OP_SRA) && data_q[31]) || (op_q == OP_ROTL));
      p1_a_d     = in_rev_d ? rev32(in_data) : in_data;
      // Second pass: SRA builds the sign mask, ROTL recovers the wrapped-out bits
      p2_a_d     = (op_q == OP_SRA) ? 32'hFFFF_FFFF : rev32(data_q);
      p2_b_d     = (op_q == OP_SRA) ? amt_q : (5'd0 - amt_q);
      p2_res_d   = (op_q == OP_SRA) ? (r1_q | ~rev_out_d) : (r1_q | rev_out_d);
   end

   // Sequencer FSM with registered handshake and shifter operand outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= 2'b00;
         data_q      <= 32'd0;
         amt_q       <= 5'd0;
         r1_q        <= 32'd0;
         result_q    <= 32'd0;
         sh_a_q      <= 32'd0;
         sh_b_q      <= 5'd0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q       <= in_op;
                  data_q     <= in_data;
                  amt_q      <= in_amt;
                  sh_a_q     <= p1_a_d;
                  sh_b_q     <= in_amt;
                  in_ready_q <= 1'b0;
                  state_q    <= ST_P1;
               end
            end
            ST_P1: begin
               r1_q <= r1_d;
               if (two_pass_d) begin
                  sh_a_q  <= p2_a_d;
                  sh_b_q  <= p2_b_d;
                  state_q <= ST_P2;
               end else begin
                  result_q    <= r1_d;
                  sh_a_q      <= 32'd0;
                  sh_b_q      <= 5'd0;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
               end
            end
            ST_P2: begin
               result_q    <= p2_res_d;
               sh_a_q      <= 32'd0;
               sh_b_q      <= 5'd0;
               out_valid_q <= 1'b1;
               state_q     <= ST_DONE;
            end
            ST_DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               sh_a_q      <= 32'd0;
               sh_b_q      <= 5'd0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_result = result_q;
   assign sh_a       = sh_a_q;
   assign sh_b       = sh_b_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed testbench for shift_sequencer with a behavioural left shifter.
module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  in_op;
   logic [31:0] in_data;
   logic [4:0]  in_amt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [31:0] sh_a;
   logic [4:0]  sh_b;
   logic [31:0] sh_out;

   int n_cmp  = 0;
   int n_fail = 0;

   shift_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_data    (in_data),
      .in_amt     (in_amt),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .sh_a       (sh_a),
      .sh_b       (sh_b),
      .sh_out     (sh_out)
   );

   assign sh_out = sh_a << sh_b;

   always #5 clk = ~clk;

   // Issue one request; returns cycles from accept to out_valid (2 = T+2) and the result
   task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [4:0] a,
                        output int lat, output logic [31:0] res);
      int guard;
      guard    = 0;
      in_op    = op;
      in_data  = d;
      in_amt   = a;
      in_valid = 1'b1;
      while (!in_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      res = out_result;
   endtask

   task automatic complete();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      n_cmp++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL reset_out_result got %h exp 0", out_result); end
      n_cmp++; if (sh_a !== 32'd0) begin n_fail++; $display("FAIL reset_sh_a got %h exp 0", sh_a); end
      n_cmp++; if (sh_b !== 5'd0) begin n_fail++; $display("FAIL reset_sh_b got %h exp 0", sh_b); end
   endtask

   task automatic test_sll();
      int lat; logic [31:0] res;
      issue(2'b00, 32'h0000_0001, 5'd31, lat, res);
      n_cmp++; if (res !== 32'h8000_0000) begin n_fail++; $display("FAIL sll31_result got %h exp 80000000", res); end
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL sll31_latency got %0d exp 2", lat); end
      complete();
      issue(2'b00, 32'hDEAD_BEEF, 5'd0, lat, res);
      n_cmp++; if (res !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL sll0_result got %h exp deadbeef", res); end
      complete();
   endtask

   task automatic test_right();
      int lat; logic [31:0] res;
      issue(2'b01, 32'h8000_0000, 5'd4, lat, res);
      n_cmp++; if (res !== 32'h0800_0000) begin n_fail++; $display("FAIL srl4_result got %h exp 08000000", res); end
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL srl4_latency got %0d exp 2", lat); end
      complete();
      issue(2'b10, 32'h8000_0000, 5'd4, lat, res);
      n_cmp++; if (res !== 32'hF800_0000) begin n_fail++; $display("FAIL sra4_neg_result got %h exp f8000000", res); end
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL sra4_neg_latency got %0d exp 3", lat); end
      complete();
   endtask

   task automatic test_sra_bounds();
      int lat; logic [31:0] res;
      issue(2'b10, 32'h7000_0000, 5'd4, lat, res);
      n_cmp++; if (res !== 32'h0700_0000) begin n_fail++; $display("FAIL sra_pos_result got %h exp 07000000", res); end
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL sra_pos_latency got %0d exp 2", lat); end
      complete();
      issue(2'b10, 32'hFFFF_FFF0, 5'd31, lat, res);
      n_cmp++; if (res !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sra31_result got %h exp ffffffff", res); end
      complete();
      issue(2'b10, 32'h8000_1234, 5'd0, lat, res);
      n_cmp++; if (res !== 32'h8000_1234) begin n_fail++; $display("FAIL sra0_result got %h exp 80001234", res); end
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL sra0_latency got %0d exp 2", lat); end
      complete();
   endtask

   task automatic test_rotl();
      int lat; logic [31:0] res;
      issue(2'b11, 32'h8000_0001, 5'd1, lat, res);
      n_cmp++; if (res !== 32'h0000_0003) begin n_fail++; $display("FAIL rotl1_result got %h exp 00000003", res); end
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL rotl1_latency got %0d exp 3", lat); end
      complete();
      issue(2'b11, 32'h1234_5678, 5'd0, lat, res);
      n_cmp++; if (res !== 32'h1234_5678) begin n_fail++; $display("FAIL rotl0_result got %h exp 12345678", res); end
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL rotl0_latency got %0d exp 2", lat); end
      complete();
      issue(2'b11, 32'h1234_5678, 5'd8, lat, res);
      n_cmp++; if (res !== 32'h3456_7812) begin n_fail++; $display("FAIL rotl8_result got %h exp 34567812", res); end
      complete();
   endtask

   task automatic test_hold_and_back_to_back();
      int lat; logic [31:0] res;
      issue(2'b00, 32'h0000_00A5, 5'd4, lat, res);
      n_cmp++; if (res !== 32'h0000_0A50) begin n_fail++; $display("FAIL hold_first_result got %h exp 00000a50", res); end
      // A competing request while in DONE must be ignored
      in_valid = 1'b1; in_op = 2'b00; in_data = 32'h0000_0001; in_amt = 5'd1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL hold_out_valid cyc %0d got %b exp 1", i, out_valid); end
         n_cmp++; if (out_result !== 32'h0000_0A50) begin n_fail++; $display("FAIL hold_out_result cyc %0d got %h exp 00000a50", i, out_result); end
         n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_in_ready cyc %0d got %b exp 0", i, in_ready); end
      end
      in_valid = 1'b0;
      complete();
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %b exp 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL release_out_valid got %b exp 0", out_valid); end
      n_cmp++; if (out_result !== 32'h0000_0A50) begin n_fail++; $display("FAIL release_result_kept got %h exp 00000a50", out_result); end
      issue(2'b01, 32'hF000_0000, 5'd8, lat, res);
      n_cmp++; if (res !== 32'h00F0_0000) begin n_fail++; $display("FAIL b2b_result got %h exp 00f00000", res); end
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_latency got %0d exp 2", lat); end
      complete();
   endtask

   task automatic test_early_ready();
      int lat; logic [31:0] res;
      out_ready = 1'b1;
      issue(2'b11, 32'hF000_000F, 5'd4, lat, res);
      n_cmp++; if (res !== 32'h0000_00FF) begin n_fail++; $display("FAIL early_ready_result got %h exp 000000ff", res); end
      n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL early_ready_latency got %0d exp 3", lat); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL early_ready_idle got %b exp 1", in_ready); end
   endtask

   task automatic test_reset_mid();
      int lat; logic [31:0] res;
      in_op = 2'b10; in_data = 32'h8000_0000; in_amt = 5'd4; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++; if (sh_a !== 32'h0000_0001) begin n_fail++; $display("FAIL p1_sh_a got %h exp 00000001", sh_a); end
      n_cmp++; if (sh_b !== 5'd4) begin n_fail++; $display("FAIL p1_sh_b got %0d exp 4", sh_b); end
      @(posedge clk); #1;
      n_cmp++; if (sh_a !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL p2_sh_a got %h exp ffffffff", sh_a); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
      n_cmp++; if (sh_a !== 32'd0) begin n_fail++; $display("FAIL midrst_sh_a got %h exp 0", sh_a); end
      n_cmp++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL midrst_result got %h exp 0", out_result); end
      issue(2'b00, 32'h0000_0003, 5'd2, lat, res);
      n_cmp++; if (res !== 32'h0000_000C) begin n_fail++; $display("FAIL post_rst_result got %h exp 0000000c", res); end
      n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL post_rst_latency got %0d exp 2", lat); end
      complete();
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_data = 32'd0; in_amt = 5'd0; out_ready = 1'b0;
      test_reset();
      test_sll();
      test_right();
      test_sra_bounds();
      test_rotl();
      test_hold_and_back_to_back();
      test_early_ready();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
